// File: rtl/multicycle_seq_control_pkg.sv
// Shared core definitions for the multi-cycle sequencer: opcodes, ALU modes,
// sequencer states and the legal-opcode list used by DECODE.
package multicycle_seq_control_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP_LUI    = 7'b0110111;
    localparam opcode_t OP_AUIPC  = 7'b0010111;
    localparam opcode_t OP_JAL    = 7'b1101111;
    localparam opcode_t OP_JALR   = 7'b1100111;
    localparam opcode_t OP_BRANCH = 7'b1100011;
    localparam opcode_t OP_LOAD   = 7'b0000011;
    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_IMM    = 7'b0010011;
    localparam opcode_t OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ALUM_ADD   = 2'd0,
        ALUM_OPEXE = 2'd1,
        ALUM_CMP   = 2'd2,
        ALUM_PASS  = 2'd3
    } alu_mode_t;

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUP, S_TRAP
    } seq_state_t;

    localparam int NUM_LEGAL = 9;
    localparam opcode_t LEGAL_OPS [NUM_LEGAL] = '{
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
        OP_LOAD, OP_STORE, OP_IMM, OP_OP
    };

    function automatic logic is_legal(input opcode_t op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_LEGAL; i++) begin
            if (op == LEGAL_OPS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/multicycle_seq_control_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side (slave).
interface multicycle_seq_control_if #(
    parameter int IDX_W = 1
);
    import multicycle_seq_control_pkg::*;

    opcode_t          opcode;
    logic             br_taken;
    logic             mem_ack;
    logic             mem_req;
    logic             mem_we;
    logic             ir_wren;
    logic             rf_wren;
    logic             pc_wren;
    logic             pc_sel;
    logic             alu_en;
    logic [IDX_W-1:0] slice_idx;
    alu_mode_t        alu_mode;
    logic             alu_a_pc;
    logic             alu_b_imm;
    logic             trap;

    modport master (
        input  opcode, br_taken, mem_ack,
        output mem_req, mem_we, ir_wren, rf_wren, pc_wren, pc_sel,
               alu_en, slice_idx, alu_mode, alu_a_pc, alu_b_imm, trap
    );

    modport slave (
        output opcode, br_taken, mem_ack,
        input  mem_req, mem_we, ir_wren, rf_wren, pc_wren, pc_sel,
               alu_en, slice_idx, alu_mode, alu_a_pc, alu_b_imm, trap
    );
endinterface

// File: rtl/multicycle_seq_control_slice_counter.sv
// Beat counter for the sliced execute phase: clear to zero, step, flag the last slice.
module multicycle_seq_control_slice_counter #(
    parameter int SLICES = 1,
    parameter int CNT_W  = $clog2(SLICES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(SLICES - 1);

    logic [CNT_W-1:0] count_reg;

    assign count = count_reg;
    assign last  = (count_reg == LAST_VAL);

    // Wrap on the last beat so a single-slice ALU keeps the counter at zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= last ? '0 : count_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/multicycle_seq_control.sv
// Multi-cycle RV32I control sequencer: fetch/decode/sliced execute/memory/writeback/PC update,
// with a valid/ack memory handshake and a sticky trap on illegal opcodes.
module multicycle_seq_control
    import multicycle_seq_control_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SLICE_W = 32
) (
    input  logic clk,
    input  logic rst,
    multicycle_seq_control_if.master bus
);
    localparam int SLICES = XLEN / SLICE_W;
    localparam int CNT_W  = $clog2(SLICES) + 1;

    seq_state_t       state_reg;
    opcode_t          cur_op_reg;
    logic             taken_reg;
    logic [CNT_W-1:0] count;
    logic             last;
    logic             cnt_clr;
    logic             cnt_inc;

    assign cnt_clr = (state_reg == S_DECODE);
    assign cnt_inc = (state_reg == S_EXEC);

    multicycle_seq_control_slice_counter #(
        .SLICES(SLICES),
        .CNT_W (CNT_W)
    ) u_slice_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(count),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_RESET;
            cur_op_reg <= '0;
            taken_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_RESET:  state_reg <= S_FETCH;
                S_FETCH:  if (bus.mem_ack) state_reg <= S_DECODE;
                S_DECODE: begin
                    cur_op_reg <= bus.opcode;
                    state_reg  <= is_legal(bus.opcode) ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    if (last) begin
                        if (cur_op_reg == OP_LOAD || cur_op_reg == OP_STORE) begin
                            state_reg <= S_MEM;
                        end else if (cur_op_reg == OP_BRANCH) begin
                            taken_reg <= bus.br_taken;
                            state_reg <= S_PCUP;
                        end else begin
                            state_reg <= S_WB;
                        end
                    end
                end
                S_MEM: begin
                    if (bus.mem_ack) state_reg <= (cur_op_reg == OP_STORE) ? S_PCUP : S_WB;
                end
                S_WB:     state_reg <= S_PCUP;
                S_PCUP:   state_reg <= S_FETCH;
                S_TRAP:   state_reg <= S_TRAP;
                default:  state_reg <= S_RESET;
            endcase
        end
    end

    // Moore decode of the registered state; only ir_wren looks at mem_ack directly.
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.ir_wren   = 1'b0;
        bus.rf_wren   = 1'b0;
        bus.pc_wren   = 1'b0;
        bus.pc_sel    = 1'b0;
        bus.alu_en    = 1'b0;
        bus.slice_idx = '0;
        bus.alu_mode  = ALUM_ADD;
        bus.alu_a_pc  = 1'b0;
        bus.alu_b_imm = 1'b0;
        bus.trap      = 1'b0;
        case (state_reg)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_wren = bus.mem_ack;
            end
            S_EXEC: begin
                bus.alu_en    = 1'b1;
                bus.slice_idx = count;
                case (cur_op_reg)
                    OP_OP, OP_IMM: bus.alu_mode = ALUM_OPEXE;
                    OP_BRANCH:     bus.alu_mode = ALUM_CMP;
                    OP_LUI:        bus.alu_mode = ALUM_PASS;
                    default:       bus.alu_mode = ALUM_ADD;
                endcase
                bus.alu_a_pc  = (cur_op_reg == OP_AUIPC) || (cur_op_reg == OP_JAL) ||
                                (cur_op_reg == OP_BRANCH);
                bus.alu_b_imm = !((cur_op_reg == OP_OP) || (cur_op_reg == OP_BRANCH));
            end
            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = (cur_op_reg == OP_STORE);
            end
            S_WB:   bus.rf_wren = 1'b1;
            S_PCUP: begin
                bus.pc_wren = 1'b1;
                bus.pc_sel  = (cur_op_reg == OP_JAL) || (cur_op_reg == OP_JALR) ||
                              ((cur_op_reg == OP_BRANCH) && taken_reg);
            end
            S_TRAP: bus.trap = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_seq_control.sv
// Bench: a per-cycle vector table on a full-width-ALU instance, then directed and random
// instructions on a byte-sliced instance checked against a phase-level reference model.
module tb_multicycle_seq_control;
    import multicycle_seq_control_pkg::*;

    localparam logic [15:0] ALL  = 16'hFFFF;
    localparam logic [15:0] CTRL = 16'hFF00;
    localparam logic [15:0] Z    = 16'h0000;
    localparam int S8 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32, rst8;
    int   total = 0;
    int   bad   = 0;

    multicycle_seq_control_if #(.IDX_W(1)) b32();
    multicycle_seq_control_if #(.IDX_W(3)) b8();

    multicycle_seq_control #(.XLEN(32), .SLICE_W(32)) dut32 (.clk(clk), .rst(rst32), .bus(b32));
    multicycle_seq_control #(.XLEN(32), .SLICE_W(8))  dut8  (.clk(clk), .rst(rst8),  .bus(b8));

    logic [15:0] obs32, obs8;
    assign obs32 = {b32.mem_req, b32.mem_we, b32.ir_wren, b32.rf_wren, b32.pc_wren, b32.pc_sel,
                    b32.alu_en, b32.trap, b32.alu_a_pc, b32.alu_b_imm, b32.alu_mode,
                    3'b000, b32.slice_idx};
    assign obs8  = {b8.mem_req, b8.mem_we, b8.ir_wren, b8.rf_wren, b8.pc_wren, b8.pc_sel,
                    b8.alu_en, b8.trap, b8.alu_a_pc, b8.alu_b_imm, b8.alu_mode,
                    1'b0, b8.slice_idx};

    function automatic logic [15:0] mk(input logic req, we, irw, rfw, pcw, sel, alu, trp,
                                       apc, bimm, input logic [1:0] mode, input logic [3:0] idx);
        return {req, we, irw, rfw, pcw, sel, alu, trp, apc, bimm, mode, idx};
    endfunction

    function automatic logic [1:0] ref_mode(input opcode_t op);
        if (op == OP_OP || op == OP_IMM) return 2'(ALUM_OPEXE);
        if (op == OP_BRANCH)             return 2'(ALUM_CMP);
        if (op == OP_LUI)                return 2'(ALUM_PASS);
        return 2'(ALUM_ADD);
    endfunction

    function automatic logic ref_legal(input opcode_t op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                          OP_LOAD, OP_STORE, OP_IMM, OP_OP};
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp,
                         input logic [15:0] mask);
        total++;
        if ((act & mask) !== (exp & mask)) begin
            bad++;
            $display("FAIL %s: got=%h want=%h mask=%h", nm, act & mask, exp & mask, mask);
        end
    endtask

    task automatic step8(input logic r, input logic ack, input logic bt, input opcode_t op,
                         input logic [15:0] exp, input logic [15:0] mask, input string nm);
        rst8 = r;
        b8.mem_ack = ack;
        b8.br_taken = bt;
        b8.opcode = op;
        @(negedge clk);
        check(nm, obs8, exp, mask);
        @(posedge clk);
        #1;
    endtask

    function automatic opcode_t junk();
        return 7'($urandom);
    endfunction

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction on the sliced instance, starting in FETCH; opcode is valid only in DECODE.
    task automatic run_instr(input opcode_t op, input int fw, input int mw, input logic taken);
        logic st, ld, br, sel;
        st  = (op == OP_STORE);
        ld  = (op == OP_LOAD);
        br  = (op == OP_BRANCH);
        sel = (op == OP_JAL) || (op == OP_JALR) || (br && taken);
        $display("instr op=%h fetch_wait=%0d mem_wait=%0d taken=%0b", op, fw, mw, taken);
        for (int i = 0; i < fw; i++)
            step8(0, 0, coin(), junk(), mk(1,0,0,0,0,0,0,0,0,0,0,0), CTRL, "fetch_wait");
        step8(0, 1, coin(), junk(), mk(1,0,1,0,0,0,0,0,0,0,0,0), CTRL, "fetch_ack");
        step8(0, coin(), coin(), op, Z, CTRL, "decode");
        if (!ref_legal(op)) begin
            for (int i = 0; i < 3; i++)
                step8(0, coin(), coin(), junk(), mk(0,0,0,0,0,0,0,1,0,0,0,0), ALL, "trap");
            return;
        end
        for (int b = 0; b < S8; b++)
            step8(0, coin(), (b == S8 - 1) ? taken : coin(), junk(),
                  mk(0,0,0,0,0,0,1,0,
                     (op == OP_AUIPC) || (op == OP_JAL) || br,
                     !((op == OP_OP) || br), ref_mode(op), 4'(b)), ALL, "exec_beat");
        if (ld || st) begin
            for (int i = 0; i < mw; i++)
                step8(0, 0, coin(), junk(), mk(1,st,0,0,0,0,0,0,0,0,0,0), CTRL, "mem_wait");
            step8(0, 1, coin(), junk(), mk(1,st,0,0,0,0,0,0,0,0,0,0), CTRL, "mem_ack");
        end
        if (!st && !br)
            step8(0, coin(), coin(), junk(), mk(0,0,0,1,0,0,0,0,0,0,0,0), CTRL, "writeback");
        step8(0, coin(), coin(), junk(), mk(0,0,0,0,1,sel,0,0,0,0,0,0), CTRL, "pc_update");
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        opcode_t     op;
        logic [15:0] exp;
        logic        chk_alu;
    } vec_t;

    vec_t    tbl [19];
    opcode_t ops [9];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, OP_OP,   Z,                                 1'b1};
        tbl[1]  = '{1'b0, 1'b1, OP_OP,   mk(1,0,1,0,0,0,0,0,0,0,0,0),       1'b0};
        tbl[2]  = '{1'b0, 1'b0, OP_OP,   Z,                                 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 7'h7F,   mk(0,0,0,0,0,0,1,0,0,0,2'(ALUM_OPEXE),0), 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 7'h7F,   mk(0,0,0,1,0,0,0,0,0,0,0,0),       1'b0};
        tbl[5]  = '{1'b0, 1'b0, 7'h7F,   mk(0,0,0,0,1,0,0,0,0,0,0,0),       1'b0};
        tbl[6]  = '{1'b0, 1'b0, OP_JAL,  mk(1,0,0,0,0,0,0,0,0,0,0,0),       1'b0};
        tbl[7]  = '{1'b0, 1'b1, OP_JAL,  mk(1,0,1,0,0,0,0,0,0,0,0,0),       1'b0};
        tbl[8]  = '{1'b0, 1'b0, OP_JAL,  Z,                                 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 7'h7F,   mk(0,0,0,0,0,0,1,0,1,1,2'(ALUM_ADD),0), 1'b1};
        tbl[10] = '{1'b0, 1'b0, 7'h7F,   mk(0,0,0,1,0,0,0,0,0,0,0,0),       1'b0};
        tbl[11] = '{1'b0, 1'b0, 7'h7F,   mk(0,0,0,0,1,1,0,0,0,0,0,0),       1'b0};
        tbl[12] = '{1'b0, 1'b1, 7'h7F,   mk(1,0,1,0,0,0,0,0,0,0,0,0),       1'b0};
        tbl[13] = '{1'b0, 1'b0, 7'h7F,   Z,                                 1'b0};
        tbl[14] = '{1'b0, 1'b1, 7'h7F,   mk(0,0,0,0,0,0,0,1,0,0,0,0),       1'b1};
        tbl[15] = '{1'b0, 1'b0, 7'h7F,   mk(0,0,0,0,0,0,0,1,0,0,0,0),       1'b1};
        tbl[16] = '{1'b1, 1'b0, 7'h7F,   mk(0,0,0,0,0,0,0,1,0,0,0,0),       1'b1};
        tbl[17] = '{1'b0, 1'b1, OP_OP,   Z,                                 1'b1};
        tbl[18] = '{1'b0, 1'b0, OP_OP,   mk(1,0,0,0,0,0,0,0,0,0,0,0),       1'b0};
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP};

        rst32 = 1'b1;
        rst8  = 1'b1;
        b32.mem_ack = 1'b0; b32.br_taken = 1'b0; b32.opcode = '0;
        b8.mem_ack  = 1'b0; b8.br_taken  = 1'b0; b8.opcode  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Full-width ALU: one vector per cycle.
        for (int i = 0; i < 19; i++) begin
            rst32 = tbl[i].rst;
            b32.mem_ack = tbl[i].ack;
            b32.opcode = tbl[i].op;
            b32.br_taken = 1'b0;
            @(negedge clk);
            $display("vec %0d rst=%0b ack=%0b op=%h out=%h", i, tbl[i].rst, tbl[i].ack,
                     tbl[i].op, obs32);
            check($sformatf("s32_vec%0d", i), obs32, tbl[i].exp, tbl[i].chk_alu ? ALL : CTRL);
            @(posedge clk);
            #1;
        end
        rst32 = 1'b1;

        // Byte-sliced ALU: directed corner cases.
        step8(0, 1, 0, OP_OP, Z, ALL, "reset_state");
        run_instr(OP_IMM, 0, 0, 0);
        run_instr(OP_LOAD, 3, 3, 0);
        run_instr(OP_BRANCH, 0, 0, 1);
        run_instr(OP_BRANCH, 1, 0, 0);
        run_instr(OP_STORE, 2, 2, 0);
        run_instr(7'h7F, 0, 0, 0);
        step8(1, 0, 0, junk(), mk(0,0,0,0,0,0,0,1,0,0,0,0), ALL, "rst_in_trap");
        step8(0, 1, 0, junk(), Z, ALL, "reset_after_trap");
        run_instr(OP_JALR, 1, 0, 0);
        step8(0, 0, 0, junk(), mk(1,0,0,0,0,0,0,0,0,0,0,0), CTRL, "fetch_before_rst");
        step8(1, 0, 0, junk(), mk(1,0,0,0,0,0,0,0,0,0,0,0), CTRL, "fetch_rst_cycle");
        step8(0, 1, 0, junk(), Z, ALL, "reset_mid_fetch");

        // Byte-sliced ALU: random legal instructions with random wait states.
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), coin());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
